// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES idle cycles, RV32I
// lane steering, load extension and alignment/range checks on a byte-lane array.

module data_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  // Not reset: contents survive reset by design.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t       req_q;
  logic [1:0] state;
  logic [3:0] cnt;

  logic                           commit;
  logic                           acc_err;
  logic [NUM_LANES-1:0]           be;
  logic [NUM_LANES-1:0][7:0]      wlane;
  logic [NUM_LANES-1:0][7:0]      rlane;
  logic [31:0]                    rword;
  logic [31:0]                    ld_data;
  logic [7:0]                     ld_byte;
  logic [15:0]                    ld_half;
  logic [1:0]                     lane;
  logic                           range_err;

  // The access is performed on the edge that leaves the last WAIT cycle.
  assign commit    = (state == S_WAIT) && (cnt == 4'd0);
  assign lane      = req_q.addr[1:0];
  assign range_err = {2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS);
  assign rword     = rlane;
  assign ld_byte   = rword[8*lane +: 8];
  assign ld_half   = req_q.addr[1] ? rword[31:16] : rword[15:0];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_mem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (commit & be[i]),
      .idx   (req_q.addr[AW+1:2]),
      .wdata (wlane[i]),
      .rdata (rlane[i])
    );
  end

  always_comb begin
    acc_err = 1'b0;
    be      = '0;
    wlane   = '0;
    ld_data = '0;
    if (req_q.we) begin
      case (req_q.f3)
        3'd0: begin
          be    = 4'b0001 << lane;
          wlane = {4{req_q.wdata[7:0]}};
        end
        3'd1: begin
          acc_err = req_q.addr[0];
          be      = req_q.addr[1] ? 4'b1100 : 4'b0011;
          wlane   = {2{req_q.wdata[15:0]}};
        end
        3'd2: begin
          acc_err = (lane != 2'd0);
          be      = 4'b1111;
          wlane   = req_q.wdata;
        end
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (req_q.f3)
        3'd0: ld_data = {{24{ld_byte[7]}}, ld_byte};
        3'd1: begin
          acc_err = req_q.addr[0];
          ld_data = {{16{ld_half[15]}}, ld_half};
        end
        3'd2: begin
          acc_err = (lane != 2'd0);
          ld_data = rword;
        end
        3'd4: ld_data = {24'd0, ld_byte};
        3'd5: begin
          acc_err = req_q.addr[0];
          ld_data = {16'd0, ld_half};
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (range_err) acc_err = 1'b1;
    if (acc_err) begin
      be      = '0;
      ld_data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      req_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_q     <= '{we: req_we, f3: req_funct3, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b0;
            cnt       <= 4'(WAIT_STATES);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
